stack_ctrl: RTL
===============

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter NWORDS, default 1024, stack depth in words; AW = $clog2(NWORDS).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous flush: empty the stack and clear errors.
REQ-006 SHALL have port push  input  1  push request, sampled each cycle.
REQ-007 SHALL have port pop  input  1  pop request, sampled each cycle.
REQ-008 SHALL have port data_in  input  WIDTH  word to push.
REQ-009 SHALL have port data_out  output  WIDTH  registered popped word.
REQ-010 SHALL have port pop_valid  output  1  one-cycle pulse: data_out updated by a pop.
REQ-011 SHALL have port full, empty  output  1 each  occupancy flags (registered).
REQ-012 SHALL have port count  output  AW+1  words currently stored, 0..NWORDS.
REQ-013 SHALL have port err  output  1  sticky error; err_code  output  2  01 overflow, 10 underflow, 00 none.
REQ-014 SHALL have port mem_we  output  1, mem_a  output  AW, mem_din  output  WIDTH  drive stack RAM (synchronous write, combinational read).
REQ-015 SHALL have port mem_dout  input  WIDTH  RAM read data for mem_a, same cycle.

Function
REQ-016 SHALL keep stack pointer sp (AW+1 bits) = next free slot; count = sp; empty = (sp==0); full = (sp==NWORDS).
REQ-017 SHALL implement FSM {RUN, ERR}; only RUN executes push/pop; ERR ignores push/pop, mem_we=0.
REQ-018 Push only, RUN, not full: mem_a=sp, mem_din=data_in, mem_we=1; sp+1 next cycle.
REQ-019 Pop only, RUN, not empty: mem_a=sp-1, mem_we=0; data_out<=mem_dout, pop_valid=1 next cycle; sp-1.
REQ-020 Push+pop, RUN, not empty (incl. full): replace top: mem_a=sp-1, mem_we=1, data_out<=old mem_dout, pop_valid=1, sp unchanged.
REQ-021 Push+pop, RUN, empty: bypass: data_out<=data_in, pop_valid=1, mem_we=0, sp stays 0, no error.
REQ-022 Push only when full: no write, sp unchanged, err_code<=01, RUN->ERR.
REQ-023 Pop only when empty: data_out unchanged, pop_valid=0, err_code<=10, RUN->ERR.
REQ-024 Idle (no push/pop) or ERR: mem_a=sp[AW-1:0] (wraps to 0 when full), mem_we=0, pop_valid=0.
REQ-025 clr has priority over push/pop: next cycle sp=0, err=0, err_code=00, state RUN, pop_valid=0, mem_we=0 that cycle; data_out holds; RAM contents untouched.
REQ-026 err SHALL equal (state==ERR); err_code holds until clr or reset.
REQ-027 SHALL never allow sp outside 0..NWORDS; mem_a always < NWORDS.
REQ-028 pop_valid SHALL be exactly one cycle per accepted pop, never asserted in ERR.

Reset
REQ-029 reset_n low SHALL immediately force: sp=0, count=0, empty=1, full=0, data_out=0, pop_valid=0, err=0, err_code=00, state RUN.
REQ-030 mem_we SHALL be 0 while reset_n low; RAM contents not cleared.
REQ-031 Reset mid-operation SHALL abort any in-flight pop (no pop_valid after release); first edge after release behaves as from empty.

Verification
REQ-032 Push 0x1111,0x2222,0x3333 then 3 pops -> data_out 0x3333,0x2222,0x1111, each with 1-cycle pop_valid one cycle after pop; empty=1 at end.
REQ-033 NWORDS=4: 4 pushes -> full=1,count=4; 5th push -> no mem_we, err=1, err_code=01; further push/pop ignored; clr -> empty=1, err=0.
REQ-034 Pop from empty -> err_code=10, pop_valid=0, data_out unchanged; clr recovers to RUN.
REQ-035 Stack holds 0xAAAA; push 0xBBBB + pop same cycle -> data_out=0xAAAA, count stays 1; next pop -> 0xBBBB.
REQ-036 Empty, push 0x5A5A + pop -> data_out=0x5A5A, pop_valid=1, count=0, err=0.
REQ-037 Assert reset_n low between pop edge and following edge -> all outputs at reset values asynchronously, no pop_valid afterward.

Source files
------------

// File: rtl/stack_if.sv
// stack_if: control, data and RAM signals between a stack controller and its environment
interface stack_if #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 1024
);
  localparam int AW = $clog2(NWORDS);
  logic             clr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             pop_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             err;
  logic [1:0]       err_code;
  logic             mem_we;
  logic [AW-1:0]    mem_a;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] mem_dout;
  modport slave (
    input  clr, push, pop, data_in, mem_dout,
    output data_out, pop_valid, full, empty, count, err, err_code, mem_we, mem_a, mem_din
  );
  modport master (
    output clr, push, pop, data_in, mem_dout,
    input  data_out, pop_valid, full, empty, count, err, err_code, mem_we, mem_a, mem_din
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO stack controller driving an external synchronous-write, combinational-read RAM
module stack_ctrl #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 1024,
  localparam int AW    = $clog2(NWORDS)
) (
  input logic    clk,
  input logic    reset_n,
  stack_if.slave s
);
  localparam logic [AW:0] FULL_SP = (AW+1)'(NWORDS);
  typedef enum logic {RUN, ERR} state_t;
  state_t      st;
  logic [AW:0] sp;
  logic [AW:0] spm1;
  logic        run, wr, rd, byp, ovf, unf;
  assign spm1    = sp - 1'b1;
  assign s.count = sp;
  assign s.empty = (sp == '0);
  assign s.full  = (sp == FULL_SP);
  assign s.err   = (st == ERR);
  // clr suppresses every operation in its cycle
  assign run = (st == RUN) && !s.clr;
  // wr covers push into free space and top replacement; rd covers pop and replacement
  assign wr  = run && s.push && (s.pop ? !s.empty : !s.full);
  assign rd  = run && s.pop && !s.empty;
  assign byp = run && s.push && s.pop && s.empty;
  assign ovf = run && s.push && !s.pop && s.full;
  assign unf = run && s.pop && !s.push && s.empty;
  // idle addressing uses the low bits of sp, which wraps to 0 when full
  assign s.mem_a   = rd ? spm1[AW-1:0] : sp[AW-1:0];
  assign s.mem_din = s.data_in;
  assign s.mem_we  = reset_n && wr;
  // stack pointer, output data, and RUN/ERR state machine with sticky error code
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= RUN;
      sp          <= '0;
      s.data_out  <= '0;
      s.pop_valid <= 1'b0;
      s.err_code  <= 2'b00;
    end else if (s.clr) begin
      st          <= RUN;
      sp          <= '0;
      s.pop_valid <= 1'b0;
      s.err_code  <= 2'b00;
    end else begin
      s.pop_valid <= rd || byp;
      if (rd) s.data_out <= s.mem_dout;
      else if (byp) s.data_out <= s.data_in;
      if (wr && !s.pop) sp <= sp + 1'b1;
      else if (rd && !s.push) sp <= spm1;
      if (ovf) begin
        st         <= ERR;
        s.err_code <= 2'b01;
      end else if (unf) begin
        st         <= ERR;
        s.err_code <= 2'b10;
      end
    end
  end
endmodule
